// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DW_DEFAULT = 8;
  localparam int CNT_W = $clog2(DW_DEFAULT);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, shifts in a dividend bit and trial-subtracts the divisor.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_r,
  input  logic          i_b,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_r,
  output logic          o_q
);
  logic [DW:0] w_s, w_t;
  assign w_s = {i_r, i_b};
  assign w_t = w_s - {1'b0, i_d};
  // With R < divisor, a negative difference always sets the top bit.
  assign o_q = ~w_t[DW];
  assign o_r = o_q ? w_t[DW-1:0] : w_s[DW-1:0];
endmodule

// File: rtl/div16u8_seq.sv
// div16u8_seq: sequential unsigned restoring divider, 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per cycle with valid/ready handshakes on both sides.
module div16u8_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);
  state_t r_state, w_next;
  logic [DW-1:0] r_rem, r_dvd, r_dvs, r_q, w_rem;
  logic [CNT_W-1:0] r_cnt;
  logic r_dz, r_ov, w_q, w_acc, w_dz, w_ov;
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_acc = in_valid && in_ready;
  assign w_dz = divisor == '0;
  assign w_ov = dividend[2*DW-1:DW] >= divisor;
  assign quotient = r_q;
  assign remainder = r_rem;
  assign div_by_zero = r_dz;
  assign overflow = r_ov;
  div_step #(.DW(DW)) u_step (
    .i_r(r_rem),
    .i_b(r_dvd[DW-1]),
    .i_d(r_dvs),
    .o_r(w_rem),
    .o_q(w_q)
  );
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_acc) w_next = (w_dz || w_ov) ? DONE : RUN;
    if (r_state == RUN && r_cnt == '0) w_next = DONE;
    if (r_state == DONE && out_ready) w_next = IDLE;
  end
  // Low dividend half shifts out MSB-first; quotient bits shift in at the LSB.
  always_ff @(posedge clk)
    if (rst) begin
      r_rem <= '0;
      r_q <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_dz <= 1'b0;
      r_ov <= 1'b0;
    end else if (w_acc) begin
      r_dvd <= dividend[DW-1:0];
      r_dvs <= divisor;
      r_cnt <= CNT_W'(DW - 1);
      r_dz <= w_dz;
      r_ov <= !w_dz && w_ov;
      r_q <= (w_dz || w_ov) ? '1 : '0;
      r_rem <= w_dz ? dividend[DW-1:0] : w_ov ? '0 : dividend[2*DW-1:DW];
    end else if (r_state == RUN) begin
      r_rem <= w_rem;
      r_q <= {r_q[DW-2:0], w_q};
      r_dvd <= r_dvd << 1;
      r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: tb/tb_div16u8_seq.sv
// tb_div16u8_seq: randomized and directed checks of div16u8_seq against an arithmetic reference model.
module tb_div16u8_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div_by_zero, overflow;
  logic [15:0] dividend = '0;
  logic [7:0] divisor = '0, quotient, remainder;
  int checks = 0, errors = 0, since = 0;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic dz;
    logic ov;
    int lat;
  } res_t;
  res_t exp_q[$];
  always #5 clk = ~clk;
  div16u8_seq #(.DW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );
  function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
    res_t m;
    int unsigned qa;
    m = '{q: 8'hFF, r: 8'h00, dz: 1'b0, ov: 1'b0, lat: 1};
    if (b == 0) begin
      m.dz = 1'b1;
      m.r = a[7:0];
    end else begin
      qa = 32'(a) / 32'(b);
      if (qa > 255) m.ov = 1'b1;
      else begin
        m.q = 8'(qa);
        m.r = 8'(32'(a) % 32'(b));
        m.lat = 9;
      end
    end
    return m;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask
  // Every cycle: handshake signals always, result fields whenever a result is due.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      since = 0;
    end else begin
      if (exp_q.size() > 0) since++;
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0 && since >= exp_q[0].lat));
      if (exp_q.size() > 0 && since >= exp_q[0].lat) begin
        chk("quotient", 32'(quotient), 32'(exp_q[0].q));
        chk("remainder", 32'(remainder), 32'(exp_q[0].r));
        chk("div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dz));
        chk("overflow", 32'(overflow), 32'(exp_q[0].ov));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(dividend, divisor));
        since = 0;
      end
    end
  end
  task automatic issue(input logic [15:0] a, input logic [7:0] b, output int lat);
    int n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    lat = n + 1;
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid still %0b after %0d cycles", out_valid, n);
    end
  endtask
  task automatic release_out(input int stall);
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic directed(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input logic eov, input int elat);
    res_t m;
    int lat;
    m = model(a, b);
    chk({name, " model q"}, 32'(m.q), 32'(eq));
    chk({name, " model r"}, 32'(m.r), 32'(er));
    issue(a, b, lat);
    chk({name, " latency"}, 32'(lat), 32'(elat));
    chk({name, " q"}, 32'(quotient), 32'(eq));
    chk({name, " r"}, 32'(remainder), 32'(er));
    chk({name, " dz"}, 32'(div_by_zero), 32'(edz));
    chk({name, " ov"}, 32'(overflow), 32'(eov));
    release_out(0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 5_000_000);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] a;
    logic [7:0] b;
    int lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset flags", 32'({div_by_zero, overflow}), 32'd0);
    directed("normal", 16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 9);
    directed("max", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9);
    directed("divzero", 16'h00AB, 8'h00, 8'hFF, 8'hAB, 1'b1, 1'b0, 1);
    directed("overflow", 16'h5600, 8'h56, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    // Backpressure: result held while new requests are offered and must be ignored.
    issue(16'h0400, 8'h20, lat);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor = 8'h01;
      @(posedge clk); #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall quotient", 32'(quotient), 32'h20);
    end
    in_valid = 1'b0;
    release_out(0);
    chk("post handshake out_valid", 32'(out_valid), 32'd0);
    chk("post handshake in_ready", 32'(in_ready), 32'd1);
    // Abort in the third RUN cycle.
    in_valid = 1'b1;
    dividend = 16'h1234;
    divisor = 8'h56;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort quotient", 32'(quotient), 32'd0);
    for (int k = 0; k < 5000; k++) begin
      b = 8'($urandom);
      a = 16'($urandom);
      if (b != 0 && $urandom_range(0, 7) != 0) a[15:8] = 8'($urandom_range(0, 32'(b) - 1));
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      issue(a, b, lat);
      if (b != 0 && a[15:8] < b) begin
        chk("recombine", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        chk("rem below divisor", 32'(remainder < b), 32'd1);
      end
      release_out($urandom_range(0, 3));
    end
    repeat (2) @(posedge clk);
    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
